axi4_burst_master: RTL and testbench

//  AXI4 initiator: turns one cache-line read/write request into a single INCR burst on io_master_*.

---
 rtl/axi4_burst_master_if.sv | 65 ++++++
 rtl/axi4_burst_master.sv | 216 +++++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_master_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) between the burst initiator and the SoC slave port.
interface axi4_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  awvalid;
    logic                  awready;
    logic [3:0]            awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [3:0]            bid;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [3:0]            arid;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [3:0]            rid;
    logic [1:0]            rresp;
    logic [DATA_W-1:0]     rdata;
    logic                  rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rresp, rdata, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rresp, rdata, rlast,
        input  rready
    );
endinterface

// File: rtl/axi4_burst_master.sv
// Cache-line AXI4 initiator: one request becomes one INCR burst, one transaction in flight.
// Address phase completes before any write beat; data beats pass through with per-beat handshakes.
module axi4_burst_master #(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [7:0]            req_len,
    input  logic [2:0]            req_size,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    output logic                  done_valid,
    output logic                  done_err,
    axi4_burst_master_if.master   io_master
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          len_r;
    logic [2:0]          size_r;
    logic [7:0]          cnt_r;
    logic                err_r;
    logic                req_ready_r;
    logic                arvalid_r;
    logic                awvalid_r;
    logic                bready_r;
    logic                done_valid_r;
    logic                done_err_r;

    logic                last_beat_s;
    logic                rready_s;
    logic                rd_valid_s;
    logic                rd_last_s;
    logic                wvalid_s;
    logic                wr_ready_s;
    logic                wlast_s;
    logic                r_hs_s;
    logic                w_hs_s;
    logic                r_err_s;
    logic                b_err_s;

    assign last_beat_s = (cnt_r == len_r);
    assign r_hs_s      = io_master.rvalid & rready_s;
    assign w_hs_s      = wvalid_s & io_master.wready;
    // An RLAST in the wrong place is flagged as an error, not used to end the burst early.
    assign r_err_s     = io_master.rresp[1] | (io_master.rid != AXI_ID) | (io_master.rlast != last_beat_s);
    assign b_err_s     = io_master.bresp[1] | (io_master.bid != AXI_ID);

    // Data-beat pass-through, only open in the matching data state.
    always_comb begin
        rready_s   = 1'b0;
        rd_valid_s = 1'b0;
        rd_last_s  = 1'b0;
        wvalid_s   = 1'b0;
        wr_ready_s = 1'b0;
        wlast_s    = 1'b0;
        case (state_r)
            ST_R: begin
                rready_s   = rd_ready;
                rd_valid_s = io_master.rvalid;
                rd_last_s  = io_master.rlast;
            end
            ST_W: begin
                wvalid_s   = wr_valid;
                wr_ready_s = io_master.wready;
                wlast_s    = last_beat_s;
            end
            default: begin
                rready_s   = 1'b0;
                wvalid_s   = 1'b0;
            end
        endcase
    end

    // Transaction FSM with registered valids/readys and completion status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            len_r        <= 8'd0;
            size_r       <= 3'd0;
            cnt_r        <= 8'd0;
            err_r        <= 1'b0;
            req_ready_r  <= 1'b1;
            arvalid_r    <= 1'b0;
            awvalid_r    <= 1'b0;
            bready_r     <= 1'b0;
            done_valid_r <= 1'b0;
            done_err_r   <= 1'b0;
        end else begin
            done_valid_r <= 1'b0;
            done_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        addr_r      <= req_addr;
                        len_r       <= req_len;
                        size_r      <= req_size;
                        cnt_r       <= 8'd0;
                        err_r       <= 1'b0;
                        req_ready_r <= 1'b0;
                        if (req_write) begin
                            state_r   <= ST_AW;
                            awvalid_r <= 1'b1;
                        end else begin
                            state_r   <= ST_AR;
                            arvalid_r <= 1'b1;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_AR: begin
                    if (io_master.arready) begin
                        arvalid_r <= 1'b0;
                        state_r   <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_hs_s) begin
                        cnt_r <= cnt_r + 8'd1;
                        err_r <= err_r | r_err_s;
                        if (last_beat_s) begin
                            state_r      <= ST_IDLE;
                            req_ready_r  <= 1'b1;
                            done_valid_r <= 1'b1;
                            done_err_r   <= err_r | r_err_s;
                        end
                    end
                end
                ST_AW: begin
                    if (io_master.awready) begin
                        awvalid_r <= 1'b0;
                        state_r   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs_s) begin
                        cnt_r <= cnt_r + 8'd1;
                        if (last_beat_s) begin
                            state_r  <= ST_B;
                            bready_r <= 1'b1;
                        end
                    end
                end
                ST_B: begin
                    if (io_master.bvalid) begin
                        bready_r     <= 1'b0;
                        err_r        <= err_r | b_err_s;
                        state_r      <= ST_IDLE;
                        req_ready_r  <= 1'b1;
                        done_valid_r <= 1'b1;
                        done_err_r   <= err_r | b_err_s;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    arvalid_r   <= 1'b0;
                    awvalid_r   <= 1'b0;
                    bready_r    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready         = req_ready_r;
    assign done_valid        = done_valid_r;
    assign done_err          = done_err_r;
    assign rd_valid          = rd_valid_s;
    assign rd_last           = rd_last_s;
    assign rd_data           = io_master.rdata;
    assign wr_ready          = wr_ready_s;

    assign io_master.arvalid = arvalid_r;
    assign io_master.arid    = AXI_ID;
    assign io_master.araddr  = addr_r;
    assign io_master.arlen   = len_r;
    assign io_master.arsize  = size_r;
    assign io_master.arburst = 2'b01;
    assign io_master.rready  = rready_s;

    assign io_master.awvalid = awvalid_r;
    assign io_master.awid    = AXI_ID;
    assign io_master.awaddr  = addr_r;
    assign io_master.awlen   = len_r;
    assign io_master.awsize  = size_r;
    assign io_master.awburst = 2'b01;
    assign io_master.wvalid  = wvalid_s;
    assign io_master.wdata   = wr_data;
    assign io_master.wstrb   = wr_strb;
    assign io_master.wlast   = wlast_s;
    assign io_master.bready  = bready_r;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Scoreboard bench: stimulus acts as client and AXI slave and queues expectations; one monitor checks.
module tb_axi4_burst_master;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ax_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } rb_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } wb_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;
    logic        rd_last;
    logic        done_valid;
    logic        done_err;

    ax_t  exp_ar_q[$];
    ax_t  exp_aw_q[$];
    rb_t  exp_rd_q[$];
    wb_t  exp_w_q[$];
    logic exp_done_q[$];

    int   total = 0;
    int   bad   = 0;
    logic aw_seen = 1'b0;

    axi4_burst_master_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    axi4_burst_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_size   (req_size),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .done_valid (done_valid),
        .done_err   (done_err),
        .io_master  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the selected handshake is present, then cross the edge that completes it.
    task automatic hs(input int which, input string nm);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 400) begin
            @(negedge clk);
            case (which)
                0: ok = req_valid && req_ready;
                1: ok = bus.arvalid && bus.arready;
                2: ok = bus.rvalid && bus.rready;
                3: ok = bus.awvalid && bus.awready;
                4: ok = bus.wvalid && bus.wready;
                5: ok = bus.bvalid && bus.bready;
                default: ok = 1'b0;
            endcase
            if (!ok) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk({nm, "_handshake"}, 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_done_q.size() != 0 && n < 8) begin
            step();
            n++;
        end
        chk("done_seen", 64'(exp_done_q.size()), 64'd0);
        exp_done_q.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input int stall_beat, input int bad_last, input int bad_resp,
                           input int bad_id, input int abort_beat, input bit fix0);
        logic [63:0] d;
        logic        lst;
        logic        err;
        err = 1'b0;
        exp_ar_q.push_back('{addr: addr, len: len, size: size});
        req_write = 1'b0;
        req_addr  = addr;
        req_len   = len;
        req_size  = size;
        req_valid = 1'b1;
        hs(0, "req");
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_len   = 8'($urandom);
        @(negedge clk);
        chk("arvalid_rise", 64'(bus.arvalid), 64'd1);
        @(posedge clk);
        #1;
        repeat ($urandom_range(0, 2)) step();
        bus.arready = 1'b1;
        hs(1, "ar");
        bus.arready = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == abort_beat) begin
                bus.rvalid = 1'b1;
                bus.rlast  = 1'b0;
                rd_ready   = 1'b0;
                rst        = 1'b1;
                step();
                rst        = 1'b0;
                rd_ready   = 1'b1;
                @(negedge clk);
                chk("abort_rready", 64'(bus.rready), 64'd0);
                chk("abort_req_ready", 64'(req_ready), 64'd1);
                chk("abort_rd_valid", 64'(rd_valid), 64'd0);
                @(posedge clk);
                #1;
                bus.rvalid = 1'b0;
                return;
            end
            repeat ($urandom_range(0, 1)) begin
                bus.rvalid = 1'b0;
                step();
            end
            d   = (fix0 && i == 0) ? 64'h1122_3344_5566_7788 : {$urandom, $urandom};
            lst = (i == int'(len)) ^ (i == bad_last);
            err = err | (i == bad_resp) | (i == bad_id) | (lst != (i == int'(len)));
            bus.rvalid = 1'b1;
            bus.rdata  = d;
            bus.rlast  = lst;
            bus.rid    = (i == bad_id) ? 4'd9 : 4'd0;
            bus.rresp  = (i == bad_resp) ? 2'b10 : 2'($urandom_range(0, 1));
            exp_rd_q.push_back('{data: d, last: lst});
            if (i == stall_beat) begin
                rd_ready = 1'b0;
                step();
                step();
                rd_ready = 1'b1;
            end
            if (i == int'(len)) exp_done_q.push_back(err);
            hs(2, "r");
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        wait_done();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input int aw_delay, input bit full_strb, input logic [1:0] bresp,
                            input logic [3:0] bid);
        logic [63:0] wd[256];
        logic [7:0]  ws[256];
        for (int i = 0; i <= int'(len); i++) begin
            wd[i] = {$urandom, $urandom};
            ws[i] = full_strb ? 8'hFF : 8'($urandom);
        end
        exp_aw_q.push_back('{addr: addr, len: len, size: size});
        req_write = 1'b1;
        req_addr  = addr;
        req_len   = len;
        req_size  = size;
        req_valid = 1'b1;
        hs(0, "req");
        req_valid = 1'b0;
        req_addr  = $urandom;
        // Client and slave are both eager; no W beat may move before AW completes.
        wr_data   = wd[0];
        wr_strb   = ws[0];
        wr_valid  = 1'b1;
        bus.wready = 1'b1;
        @(negedge clk);
        chk("awvalid_rise", 64'(bus.awvalid), 64'd1);
        @(posedge clk);
        #1;
        repeat (aw_delay) step();
        bus.awready = 1'b1;
        hs(3, "aw");
        bus.awready = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wr_data = wd[i];
            wr_strb = ws[i];
            exp_w_q.push_back('{data: wd[i], strb: ws[i], last: (i == int'(len))});
            bus.wready = 1'b0;
            repeat ($urandom_range(0, 1)) step();
            bus.wready = 1'b1;
            hs(4, "w");
        end
        wr_valid   = 1'b0;
        bus.wready = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        bus.bvalid = 1'b1;
        bus.bresp  = bresp;
        bus.bid    = bid;
        exp_done_q.push_back(bresp[1] | (bid != 4'd0));
        hs(5, "b");
        bus.bvalid = 1'b0;
        wait_done();
    endtask

    // Monitor: every observed handshake or completion is compared against the queued expectation.
    always @(negedge clk) begin
        ax_t  a;
        rb_t  rb;
        wb_t  wb;
        logic de;
        if (rst === 1'b0) begin
            if (bus.arvalid && bus.arready) begin
                chk("ar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
                if (exp_ar_q.size() != 0) begin
                    a = exp_ar_q.pop_front();
                    chk("araddr", 64'(bus.araddr), 64'(a.addr));
                    chk("arlen", 64'(bus.arlen), 64'(a.len));
                    chk("arsize", 64'(bus.arsize), 64'(a.size));
                    chk("arburst", 64'(bus.arburst), 64'd1);
                    chk("arid", 64'(bus.arid), 64'd0);
                end
            end
            if (bus.awvalid && bus.awready) begin
                chk("aw_expected", 64'(exp_aw_q.size() != 0), 64'd1);
                if (exp_aw_q.size() != 0) begin
                    a = exp_aw_q.pop_front();
                    chk("awaddr", 64'(bus.awaddr), 64'(a.addr));
                    chk("awlen", 64'(bus.awlen), 64'(a.len));
                    chk("awsize", 64'(bus.awsize), 64'(a.size));
                    chk("awburst", 64'(bus.awburst), 64'd1);
                    chk("awid", 64'(bus.awid), 64'd0);
                end
                aw_seen <= 1'b1;
            end
            if (bus.wvalid) begin
                chk("w_after_aw", 64'(aw_seen), 64'd1);
                chk("wr_ready_follow", 64'(wr_ready), 64'(bus.wready));
            end
            if (bus.wvalid && bus.wready) begin
                chk("w_expected", 64'(exp_w_q.size() != 0), 64'd1);
                if (exp_w_q.size() != 0) begin
                    wb = exp_w_q.pop_front();
                    chk("wdata", bus.wdata, wb.data);
                    chk("wstrb", 64'(bus.wstrb), 64'(wb.strb));
                    chk("wlast", 64'(bus.wlast), 64'(wb.last));
                    if (wb.last) aw_seen <= 1'b0;
                end
            end
            if (rd_valid) chk("rready_follow", 64'(bus.rready), 64'(rd_ready));
            if (rd_valid && rd_ready) begin
                chk("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
                if (exp_rd_q.size() != 0) begin
                    rb = exp_rd_q.pop_front();
                    chk("rd_data", rd_data, rb.data);
                    chk("rd_last", 64'(rd_last), 64'(rb.last));
                end
            end
            if (done_valid) begin
                chk("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
                chk("done_after_beats", 64'(exp_rd_q.size() + exp_w_q.size()), 64'd0);
                if (exp_done_q.size() != 0) begin
                    de = exp_done_q.pop_front();
                    chk("done_err", 64'(done_err), 64'(de));
                end
            end
        end else begin
            aw_seen <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  l;
        logic [31:0] a;
        logic [2:0]  s;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_len = 8'd0; req_size = 3'd0;
        wr_valid = 1'b1; wr_data = 64'd0; wr_strb = 8'd0; rd_ready = 1'b1;
        bus.awready = 1'b0; bus.wready = 1'b1; bus.bvalid = 1'b1; bus.bid = 4'd0; bus.bresp = 2'b00;
        bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rresp = 2'b00;
        bus.rdata = 64'd0; bus.rlast = 1'b0;

        // Reset held 3 cycles with busy-looking inputs: nothing may be driven valid.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c > 0) begin
                chk("rst_done_valid", 64'(done_valid), 64'd0);
                chk("rst_req_ready", 64'(req_ready), 64'd1);
            end
        end
        chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
        chk("rst_awvalid", 64'(bus.awvalid), 64'd0);
        chk("rst_wvalid", 64'(bus.wvalid), 64'd0);
        chk("rst_rready", 64'(bus.rready), 64'd0);
        chk("rst_bready", 64'(bus.bready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.rvalid = 1'b0;
        rst = 1'b0;
        step();

        do_read(32'h8000_0000, 8'd0, 3'd3, -1, -1, -1, -1, -1, 1'b1);
        do_read(32'h8000_0040, 8'd3, 3'd3, 1, -1, -1, -1, -1, 1'b0);
        do_write(32'h8000_0100, 8'd3, 3'd3, 3, 1'b1, 2'b00, 4'd0);
        do_write(32'h8000_0200, 8'd0, 3'd3, 0, 1'b1, 2'b10, 4'd0);
        do_read(32'h8000_0300, 8'd3, 3'd3, -1, 1, -1, -1, -1, 1'b0);
        do_read(32'h8000_0400, 8'd7, 3'd3, -1, -1, -1, -1, 1, 1'b0);
        do_read(32'h8000_0500, 8'd7, 3'd3, -1, -1, -1, -1, -1, 1'b0);

        // Stray R beat and B response while idle must be neither accepted nor completed.
        bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.bvalid = 1'b1;
        @(negedge clk);
        chk("idle_rready", 64'(bus.rready), 64'd0);
        chk("idle_rd_valid", 64'(rd_valid), 64'd0);
        step();
        step();
        bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.bvalid = 1'b0;
        step();

        for (int k = 0; k < 40; k++) begin
            l = 8'($urandom_range(0, 15));
            a = $urandom;
            s = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, l, s, int'($urandom_range(0, 3)), 1'b0,
                         ($urandom_range(0, 5) == 0) ? 2'b10 : 2'($urandom_range(0, 1)),
                         ($urandom_range(0, 7) == 0) ? 4'd3 : 4'd0);
            else
                do_read(a, l, s,
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l))) : -1,
                        ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(l))) : -1,
                        ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(l))) : -1,
                        ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(l))) : -1,
                        -1, 1'b0);
        end

        do_read(32'h9000_0000, 8'd255, 3'd3, 200, -1, -1, -1, -1, 1'b0);
        do_write(32'h9000_1000, 8'd255, 3'd3, 1, 1'b0, 2'b00, 4'd0);

        step();
        chk("queues_empty", 64'(exp_ar_q.size() + exp_aw_q.size() + exp_rd_q.size()
                                + exp_w_q.size() + exp_done_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
